// File: rtl/operand_fetch.sv
// operand_fetch: RV32I decode / operand-fetch stage between fetch and execute.
//
// Decodes register fields and the immediate, drives the register-file read
// indices, takes the read data with a same-cycle writeback bypass, and blocks
// RAW/WAW hazards with a 32-entry busy scoreboard. Results go to execute
// through a valid/ready ID/EX register.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     fetch handshake; in_pc, in_instr carry the instruction
//   ra1, ra2              register-file read indices (combinational)
//   rd1, rd2              register-file read data (pre-write contents)
//   wb_en/wb_addr/wb_data writeback port, also used for the bypass
//   flush                 kill the ID/EX entry
//   out_valid/out_ready   ID/EX handshake
//   out_pc, out_op1, out_op2, out_imm, out_rd, out_rd_wen, out_illegal
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic        out_illegal
);

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        use_rs1, use_rs2, write_rd, illegal;
  imm_fmt_e    imm_fmt;
  logic [31:0] imm;
  logic        rd_wen;
  logic [31:0] op1, op2;

  logic        out_valid_q, out_rd_wen_q, out_illegal_q;
  logic [31:0] out_pc_q, out_op1_q, out_op2_q, out_imm_q;
  logic [4:0]  out_rd_q;

  // Bit 0 is never set: out_rd_wen is never raised for x0.
  logic [31:0] busy_q, busy_d, wb_mask, busy_eff;
  logic        out_hs, hazard, accept;
  logic        conf_rs1, conf_rs2, conf_rd;

  assign opcode = in_instr[6:0];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];
  assign ra1    = rs1;
  assign ra2    = rs2;

  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    write_rd = 1'b0;
    illegal  = 1'b0;
    imm_fmt  = ImmNone;
    case (opcode)
      7'b0110111, 7'b0010111: begin write_rd = 1'b1; imm_fmt = ImmU; end
      7'b1101111:             begin write_rd = 1'b1; imm_fmt = ImmJ; end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        use_rs1  = 1'b1;
        write_rd = 1'b1;
        imm_fmt  = ImmI;
      end
      7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_fmt = ImmB; end
      7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_fmt = ImmS; end
      7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; write_rd = 1'b1; end
      default:    illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_fmt)
      ImmI: imm = {{20{in_instr[31]}}, in_instr[31:20]};
      ImmS: imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      ImmB: imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      ImmU: imm = {in_instr[31:12], 12'b0};
      ImmJ: imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign rd_wen = write_rd && (rd != 5'd0);

  // The register file does not hardwire x0, so index 0 reads are forced here.
  assign op1 = (rs1 == 5'd0) ? 32'd0 :
               (wb_en && (wb_addr == rs1)) ? wb_data : rd1;
  assign op2 = (rs2 == 5'd0) ? 32'd0 :
               (wb_en && (wb_addr == rs2)) ? wb_data : rd2;

  // A writeback this cycle releases its register for the instruction being accepted.
  assign wb_mask  = wb_en ? (32'd1 << wb_addr) : 32'd0;
  assign busy_eff = busy_q & ~wb_mask;
  assign out_hs   = out_valid_q && out_ready;

  // The entry sitting in ID/EX has not set its busy bit yet, so match it directly.
  assign conf_rs1 = use_rs1 && (rs1 != 5'd0) &&
                    (busy_eff[rs1] || (out_valid_q && out_rd_wen_q && (out_rd_q == rs1)));
  assign conf_rs2 = use_rs2 && (rs2 != 5'd0) &&
                    (busy_eff[rs2] || (out_valid_q && out_rd_wen_q && (out_rd_q == rs2)));
  assign conf_rd  = rd_wen &&
                    (busy_eff[rd] || (out_valid_q && out_rd_wen_q && (out_rd_q == rd)));
  assign hazard   = conf_rs1 || conf_rs2 || conf_rd;

  assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Clear first, then set, so an issue wins over a same-index writeback.
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (out_hs && out_rd_wen_q) begin
      busy_d[out_rd_q] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
      out_imm_q     <= '0;
      out_rd_q      <= '0;
      out_rd_wen_q  <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q   <= 1'b1;
        out_pc_q      <= in_pc;
        out_op1_q     <= op1;
        out_op2_q     <= op2;
        out_imm_q     <= imm;
        out_rd_q      <= rd;
        out_rd_wen_q  <= rd_wen;
        out_illegal_q <= illegal;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_op1     = out_op1_q;
  assign out_op2     = out_op2_q;
  assign out_imm     = out_imm_q;
  assign out_rd      = out_rd_q;
  assign out_rd_wen  = out_rd_wen_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch. Stimulus pushes the
// expected ID/EX contents into a queue on each accepted instruction; a monitor
// pops and compares on every output handshake.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] in_pc, in_instr;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_pc, out_op1, out_op2, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_wen, out_illegal;

  operand_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_imm    (out_imm),
    .out_rd     (out_rd),
    .out_rd_wen (out_rd_wen),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic        wen, ill;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc       = 32'h100;
  logic [31:0] held_pc;

  localparam logic [31:0] Junk = 32'hDEADBEEF;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic wen, input logic ill);
    exp_t e;
    e.pc  = 32'd0;
    e.op1 = op1;
    e.op2 = op2;
    e.imm = imm;
    e.rd  = rd;
    e.wen = wen;
    e.ill = ill;
    return e;
  endfunction

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for one cycle and check in_ready before the edge.
  task automatic offer(input logic [31:0] instr, input logic exp_rdy, input logic push,
                       input exp_t e);
    exp_t x;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy && push) begin
      x    = e;
      x.pc = pc;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc       = pc + 32'd4;
  endtask

  task automatic wb_set(input logic [4:0] a, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic wb_clr();
    wb_en   = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output_pc", out_pc, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_op1", out_op1, e.op1);
        check("out_op2", out_op2, e.op2);
        check("out_imm", out_imm, e.imm);
        check("out_rd_wen", {31'd0, out_rd_wen}, {31'd0, e.wen});
        check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        if (e.wen) check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  exp_t none;

  initial begin
    none      = mk(0, 0, 0, 0, 0, 0);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093;
    in_pc     = 32'd0;
    rd1       = Junk;
    rd2       = Junk;
    flush     = 1'b0;
    out_ready = 1'b1;
    wb_clr();

    // Reset
    @(negedge clk);
    check("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    idle();
    @(negedge clk);
    check("in_ready_in_rst2", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_rd_wen", {31'd0, out_rd_wen}, 32'd0);
    idle();
    rst      = 1'b0;
    in_valid = 1'b0;

    // Read indices
    in_instr = 32'h00500093;
    #1;
    check("ra1", {27'd0, ra1}, 32'd0);
    check("ra2", {27'd0, ra2}, 32'd5);

    // ADDI x1,x0,5 then dependent ADD x2,x1,x1 via bypass
    offer(32'h00500093, 1'b1, 1'b1, mk(0, Junk, 5, 1, 1, 0));
    offer(32'h00108133, 1'b0, 1'b0, none);
    offer(32'h00108133, 1'b0, 1'b0, none);
    wb_set(1, 32'h5);
    offer(32'h00108133, 1'b1, 1'b1, mk(5, 5, 0, 2, 1, 0));
    wb_clr();
    idle();
    wb_set(2, 32'h0);
    idle();
    wb_clr();

    // Producer x3 held in ID/EX, SW x3,0(x4) stalls until writeback
    out_ready = 1'b0;
    held_pc   = pc;
    offer(32'h00100193, 1'b1, 1'b1, mk(0, Junk, 1, 3, 1, 0));
    offer(32'h00322023, 1'b0, 1'b0, none);
    offer(32'h00322023, 1'b0, 1'b0, none);
    check("held_out_valid", {31'd0, out_valid}, 32'd1);
    check("held_out_pc", out_pc, held_pc);
    out_ready = 1'b1;
    offer(32'h00322023, 1'b0, 1'b0, none);
    offer(32'h00322023, 1'b0, 1'b0, none);
    wb_set(3, 32'h33);
    offer(32'h00322023, 1'b1, 1'b1, mk(Junk, 32'h33, 0, 0, 0, 0));
    wb_clr();
    idle();

    // Set and clear of x7 in the same cycle: set wins
    offer(32'h00700393, 1'b1, 1'b1, mk(0, Junk, 7, 7, 1, 0));
    wb_set(7, 32'h0);
    idle();
    wb_clr();
    offer(32'h00038413, 1'b0, 1'b0, none);
    wb_set(7, 32'h70);
    offer(32'h00038413, 1'b1, 1'b1, mk(32'h70, 0, 0, 8, 1, 0));
    wb_clr();
    idle();
    wb_set(8, 32'h0);
    idle();
    wb_clr();

    // Immediates and illegal opcode, back to back
    offer(32'hFE000EE3, 1'b1, 1'b1, mk(0, 0, 32'hFFFFFFFC, 29, 0, 0));
    offer(32'h0000007F, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 1));
    offer(32'hFE002C23, 1'b1, 1'b1, mk(0, 0, 32'hFFFFFFF8, 24, 0, 0));
    offer(32'h123452B7, 1'b1, 1'b1, mk(Junk, Junk, 32'h12345000, 5, 1, 0));
    offer(32'h008000EF, 1'b1, 1'b1, mk(0, Junk, 8, 1, 1, 0));
    idle();

    // Flush of a held entry in the same cycle as an offer
    out_ready = 1'b0;
    offer(32'h00900493, 1'b1, 1'b0, none);
    flush = 1'b1;
    offer(32'h00A00513, 1'b0, 1'b0, none);
    flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    offer(32'h00048593, 1'b1, 1'b1, mk(Junk, 0, 0, 11, 1, 0));
    offer(32'h00108133, 1'b0, 1'b0, none);

    // Reset mid-stall clears busy and the ID/EX entry
    out_ready = 1'b0;
    offer(32'h00C00613, 1'b1, 1'b0, none);
    rst = 1'b1;
    offer(32'h00108133, 1'b0, 1'b0, none);
    rst = 1'b0;
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_out_pc", out_pc, 32'd0);
    check("rst2_out_imm", out_imm, 32'd0);
    check("rst2_out_rd_wen", {31'd0, out_rd_wen}, 32'd0);
    out_ready = 1'b1;
    offer(32'h00108133, 1'b1, 1'b1, mk(Junk, Junk, 0, 2, 1, 0));
    idle();
    idle();
    idle();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
